// File: rtl/cellrv32_spi_target_phy.sv
// SPI target PHY: oversamples SPI pins on clk_i, shifts MOSI in and MISO out (MSB first).
// Optional macro CELLRV32_SPI_TGT_CLK_FILTER_EN adds a 2-sample glitch filter on the synced SPI clock.
module cellrv32_spi_target_phy #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cf_enable_i,
  input  logic       cf_cpha_i,
  input  logic       cf_cpol_i,
  input  logic       spi_csn_i,
  input  logic       spi_clk_i,
  input  logic       spi_dat_i,
  output logic       spi_dat_o,
  output logic       spi_dat_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       rx_abort_o,
  output logic       busy_o
);

  localparam logic [1:0] S_ARM    = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic                   srst_s;
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] csn_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_s;
  logic                   csn_s;
  logic                   dat_s;
  logic                   clk_lvl_s;
  logic                   clk_prev_r;
  logic                   edge_s;
  logic                   lead_s;
  logic                   trail_s;
  logic                   sample_s;
  logic                   shift_s;

  logic [1:0]             state_r;
  logic [7:0]             hold_r;
  logic                   hold_full_r;
  logic [7:0]             txs_r;
  logic [7:0]             rxs_r;
  logic [7:0]             rxs_next_s;
  logic [2:0]             bitcnt_r;
  logic                   byte_done_r;
  logic                   dat_r;
  logic [7:0]             rx_data_r;
  logic                   rx_valid_r;
  logic                   frame_start_r;
  logic                   frame_end_r;
  logic                   rx_abort_r;
  logic                   tx_underrun_r;
  logic [7:0]             next_byte_s;
  logic                   start_s;
  logic                   reload_s;
  logic                   write_s;

  // Disabled module behaves exactly like a reset.
  assign srst_s = rst_i | ~cf_enable_i;

  // Pin synchronizers; CS resets to "asserted" so S_ARM waits for a real deassertion.
  always_ff @(posedge clk_i) begin
    if (srst_s) begin
      clk_sync_r <= {SYNC_STAGES{1'b0}};
      csn_sync_r <= {SYNC_STAGES{1'b0}};
      dat_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], spi_clk_i};
      csn_sync_r <= {csn_sync_r[SYNC_STAGES-2:0], spi_csn_i};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], spi_dat_i};
    end
  end

  assign clk_s = clk_sync_r[SYNC_STAGES-1];
  assign csn_s = csn_sync_r[SYNC_STAGES-1];
  assign dat_s = dat_sync_r[SYNC_STAGES-1];

`ifdef CELLRV32_SPI_TGT_CLK_FILTER_EN
  logic clk_d_r;

  // One-cycle delayed copy of the synced clock for the agreement check.
  always_ff @(posedge clk_i) begin
    if (srst_s) begin
      clk_d_r <= 1'b0;
    end else begin
      clk_d_r <= clk_s;
    end
  end

  // Accept a new clock level only after two equal consecutive samples.
  always_comb begin
    if (clk_s == clk_d_r) begin
      clk_lvl_s = clk_s;
    end else begin
      clk_lvl_s = clk_prev_r;
    end
  end
`else
  // Raw synced level is used directly.
  always_comb begin
    clk_lvl_s = clk_s;
  end
`endif

  // Previous accepted clock level for edge detection.
  always_ff @(posedge clk_i) begin
    if (srst_s) begin
      clk_prev_r <= 1'b0;
    end else begin
      clk_prev_r <= clk_lvl_s;
    end
  end

  // Edge classification and transfer-control decode.
  always_comb begin
    edge_s      = clk_lvl_s ^ clk_prev_r;
    lead_s      = edge_s & (clk_lvl_s ^ cf_cpol_i);
    trail_s     = edge_s & ~(clk_lvl_s ^ cf_cpol_i);
    sample_s    = cf_cpha_i ? trail_s : lead_s;
    shift_s     = cf_cpha_i ? lead_s : trail_s;
    next_byte_s = hold_full_r ? hold_r : TX_IDLE_BYTE;
    rxs_next_s  = {rxs_r[6:0], dat_s};
    start_s     = (state_r == S_IDLE) & ~csn_s;
    reload_s    = start_s |
                  ((state_r == S_ACTIVE) & ~csn_s & shift_s & byte_done_r);
    write_s     = tx_valid_i & ~hold_full_r;
  end

  // Frame FSM, shift registers and transmit holding register.
  always_ff @(posedge clk_i) begin
    if (srst_s) begin
      state_r       <= S_ARM;
      hold_r        <= 8'h00;
      hold_full_r   <= 1'b0;
      txs_r         <= 8'h00;
      rxs_r         <= 8'h00;
      bitcnt_r      <= 3'd0;
      byte_done_r   <= 1'b0;
      dat_r         <= 1'b0;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      rx_abort_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      rx_abort_r    <= 1'b0;
      // A reload sees the pre-write state; a same-cycle write still fills the register.
      tx_underrun_r <= reload_s & ~hold_full_r;
      hold_full_r   <= (hold_full_r & ~reload_s) | write_s;
      if (write_s) begin
        hold_r <= tx_data_i;
      end

      case (state_r)
        S_ARM: begin
          if (csn_s) begin
            state_r <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!csn_s) begin
            state_r       <= S_ACTIVE;
            frame_start_r <= 1'b1;
            bitcnt_r      <= 3'd0;
            byte_done_r   <= 1'b0;
            rxs_r         <= 8'h00;
            txs_r         <= next_byte_s;
            dat_r         <= cf_cpha_i ? 1'b0 : next_byte_s[7];
          end
        end
        S_ACTIVE: begin
          if (csn_s) begin
            state_r     <= S_IDLE;
            frame_end_r <= 1'b1;
            rx_abort_r  <= (bitcnt_r != 3'd0);
            bitcnt_r    <= 3'd0;
            byte_done_r <= 1'b0;
            rxs_r       <= 8'h00;
            txs_r       <= 8'h00;
            dat_r       <= 1'b0;
          end else if (sample_s) begin
            rxs_r    <= rxs_next_s;
            bitcnt_r <= bitcnt_r + 3'd1;
            if (bitcnt_r == 3'd7) begin
              rx_data_r   <= rxs_next_s;
              rx_valid_r  <= 1'b1;
              byte_done_r <= 1'b1;
            end
          end else if (shift_s) begin
            // With cpha=1 the shift edge both presents the current MSB and advances.
            if (byte_done_r) begin
              byte_done_r <= 1'b0;
              if (cf_cpha_i) begin
                dat_r <= next_byte_s[7];
                txs_r <= {next_byte_s[6:0], 1'b0};
              end else begin
                dat_r <= next_byte_s[7];
                txs_r <= next_byte_s;
              end
            end else begin
              if (cf_cpha_i) begin
                dat_r <= txs_r[7];
              end else begin
                dat_r <= txs_r[6];
              end
              txs_r <= {txs_r[6:0], 1'b0};
            end
          end
        end
        default: begin
          state_r <= S_ARM;
        end
      endcase
    end
  end

  assign spi_dat_o     = dat_r;
  assign spi_dat_oe_o  = (state_r == S_ACTIVE);
  assign busy_o        = (state_r == S_ACTIVE);
  assign tx_ready_o    = ~hold_full_r;
  assign tx_underrun_o = tx_underrun_r;
  assign rx_data_o     = rx_data_r;
  assign rx_valid_o    = rx_valid_r;
  assign frame_start_o = frame_start_r;
  assign frame_end_o   = frame_end_r;
  assign rx_abort_o    = rx_abort_r;

endmodule

// File: tb/tb_cellrv32_spi_target_phy.sv
// Directed bench for cellrv32_spi_target_phy: table of single-byte frames plus multi-cycle corner cases.
module tb_cellrv32_spi_target_phy;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       cf_enable;
  logic       cf_cpha;
  logic       cf_cpol;
  logic       spi_csn;
  logic       spi_clk;
  logic       spi_dat;
  logic       spi_dat_o;
  logic       spi_dat_oe_o;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready_o;
  logic       tx_underrun_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_start_o;
  logic       frame_end_o;
  logic       rx_abort_o;
  logic       busy_o;

  always #5 clk = ~clk;

  cellrv32_spi_target_phy dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cf_enable_i   (cf_enable),
    .cf_cpha_i     (cf_cpha),
    .cf_cpol_i     (cf_cpol),
    .spi_csn_i     (spi_csn),
    .spi_clk_i     (spi_clk),
    .spi_dat_i     (spi_dat),
    .spi_dat_o     (spi_dat_o),
    .spi_dat_oe_o  (spi_dat_oe_o),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .tx_underrun_o (tx_underrun_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o),
    .rx_abort_o    (rx_abort_o),
    .busy_o        (busy_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int n_rxv = 0, n_start = 0, n_end = 0, n_abort = 0, n_under = 0;
  logic [7:0] rx_log[$];

  bit   mon_en     = 1'b0;
  bit   last_shift = 1'b0;
  logic prev_dat   = 1'b0;
  logic prev_busy  = 1'b0;
  int   n_trans = 0, n_bad = 0;

  logic [7:0]  host_tx [0:2];
  logic [23:0] host_miso;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] pre;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse counters and MISO transition monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_o) begin
      n_rxv++;
      rx_log.push_back(rx_data_o);
    end
    if (frame_start_o) n_start++;
    if (frame_end_o)   n_end++;
    if (rx_abort_o)    n_abort++;
    if (tx_underrun_o) n_under++;
    if (mon_en && busy_o && prev_busy && (spi_dat_o !== prev_dat)) begin
      n_trans++;
      if (!last_shift) n_bad++;
    end
    prev_dat  = spi_dat_o;
    prev_busy = busy_o;
  end

  task automatic tx_write(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha);
    cf_cpol = cpol;
    cf_cpha = cpha;
    spi_clk = cpol;
    cyc(10);
  endtask

  // Host side of one frame; with cpha=0 CS is released before the final trailing edge.
  task automatic spi_frame(input int nbits, input int rst_bit, input bit do_wr, input logic [7:0] wr_byte);
    logic b;
    host_miso = 24'h0;
    spi_csn   = 1'b0;
    cyc(8);
    if (do_wr) begin
      check("tx_ready_after_start", {31'd0, tx_ready_o}, 32'd1);
      tx_write(wr_byte);
    end
    for (int i = 0; i < nbits; i++) begin
      b = host_tx[i/8][7 - (i % 8)];
      if (i == rst_bit) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
      end
      if (!cf_cpha) begin
        spi_dat = b;
        cyc(H);
        host_miso  = {host_miso[22:0], spi_dat_o};
        spi_clk    = ~cf_cpol;
        last_shift = 1'b0;
        cyc(H);
        if (i != nbits - 1) begin
          spi_clk    = cf_cpol;
          last_shift = 1'b1;
        end
      end else begin
        cyc(H);
        spi_clk    = ~cf_cpol;
        last_shift = 1'b1;
        spi_dat    = b;
        cyc(H);
        host_miso  = {host_miso[22:0], spi_dat_o};
        spi_clk    = cf_cpol;
        last_shift = 1'b0;
      end
    end
    cyc(H);
    spi_csn = 1'b1;
    cyc(H);
    spi_clk = cf_cpol;
    cyc(10);
  endtask

  initial begin
    int s_rxv, s_start, s_end, s_abort, s_under, exp_abort;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, pre: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C};
    vecs[1] = '{cpol: 1'b0, cpha: 1'b1, pre: 8'h5A, mosi: 8'h81, exp_miso: 8'h5A, exp_rx: 8'h81};
    vecs[2] = '{cpol: 1'b1, cpha: 1'b0, pre: 8'hC3, mosi: 8'h81, exp_miso: 8'hC3, exp_rx: 8'h81};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b1, pre: 8'h96, mosi: 8'h7E, exp_miso: 8'h96, exp_rx: 8'h7E};

    rst       = 1'b1;
    cf_enable = 1'b1;
    cf_cpha   = 1'b0;
    cf_cpol   = 1'b0;
    spi_csn   = 1'b1;
    spi_clk   = 1'b0;
    spi_dat   = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    cyc(5);
    rst = 1'b0;
    cyc(1);

    check("reset_busy",     {31'd0, busy_o},       32'd0);
    check("reset_oe",       {31'd0, spi_dat_oe_o}, 32'd0);
    check("reset_miso",     {31'd0, spi_dat_o},    32'd0);
    check("reset_tx_ready", {31'd0, tx_ready_o},   32'd1);
    check("reset_rx_data",  {24'd0, rx_data_o},    32'h00);
    cyc(10);
    check("reset_no_pulses", 32'(n_rxv + n_start + n_end + n_abort + n_under), 32'd0);

    // Single-byte frames in all four modes.
    mon_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      set_mode(vecs[v].cpol, vecs[v].cpha);
      tx_write(vecs[v].pre);
      check("tx_ready_full", {31'd0, tx_ready_o}, 32'd0);
      s_rxv = n_rxv; s_start = n_start; s_end = n_end; s_abort = n_abort; s_under = n_under;
      host_tx[0] = vecs[v].mosi;
      spi_frame(8, -1, 1'b0, 8'h00);
      check("vec_miso",     {24'd0, host_miso[7:0]}, {24'd0, vecs[v].exp_miso});
      check("vec_rx_data",  {24'd0, rx_data_o},      {24'd0, vecs[v].exp_rx});
      check("vec_rx_valid", 32'(n_rxv - s_rxv),      32'd1);
      check("vec_start",    32'(n_start - s_start),  32'd1);
      check("vec_end",      32'(n_end - s_end),      32'd1);
      check("vec_abort",    32'(n_abort - s_abort),  32'd0);
      check("vec_underrun", 32'(n_under - s_under),  32'd0);
      check("vec_busy_end", {31'd0, busy_o},         32'd0);
    end

    // Mode 3, three bytes, second byte written after the first reload.
    set_mode(1'b1, 1'b1);
    tx_write(8'h11);
    s_rxv = n_rxv; s_under = n_under;
    host_tx[0] = 8'h03; host_tx[1] = 8'h12; host_tx[2] = 8'h34;
    spi_frame(24, -1, 1'b1, 8'h22);
    check("m3_miso",     {8'd0, host_miso},      32'h1122FF);
    check("m3_rx_valid", 32'(n_rxv - s_rxv),     32'd3);
    check("m3_underrun", 32'(n_under - s_under), 32'd1);
    check("m3_rx0", {24'd0, rx_log[rx_log.size()-3]}, 32'h03);
    check("m3_rx1", {24'd0, rx_log[rx_log.size()-2]}, 32'h12);
    check("m3_rx2", {24'd0, rx_log[rx_log.size()-1]}, 32'h34);
    mon_en = 1'b0;
    check("miso_transitions_seen", {31'd0, n_trans > 0}, 32'd1);
    check("miso_only_on_shift",    32'(n_bad),           32'd0);

    // CS released after 5 bits, then a normal frame.
    set_mode(1'b0, 1'b0);
    s_rxv = n_rxv; s_end = n_end; s_abort = n_abort;
    host_tx[0] = 8'hF0;
    spi_frame(5, -1, 1'b0, 8'h00);
    check("abort_pulse",    32'(n_abort - s_abort), 32'd1);
    check("abort_end",      32'(n_end - s_end),     32'd1);
    check("abort_no_valid", 32'(n_rxv - s_rxv),     32'd0);
    s_rxv = n_rxv; s_abort = n_abort;
    host_tx[0] = 8'h55;
    spi_frame(8, -1, 1'b0, 8'h00);
    check("after_abort_rx",    {24'd0, rx_data_o},     32'h55);
    check("after_abort_valid", 32'(n_rxv - s_rxv),     32'd1);
    check("after_abort_abort", 32'(n_abort - s_abort), 32'd0);

    // Reset mid-frame with CS held low: target stays out of the frame.
    s_rxv = n_rxv; s_start = n_start; s_end = n_end;
    host_tx[0] = 8'hFF;
    spi_frame(8, 3, 1'b0, 8'h00);
    check("rst_mid_no_valid", 32'(n_rxv - s_rxv),     32'd0);
    check("rst_mid_start",    32'(n_start - s_start), 32'd1);
    check("rst_mid_no_end",   32'(n_end - s_end),     32'd0);
    check("rst_mid_rx_data",  {24'd0, rx_data_o},     32'h00);
    s_rxv = n_rxv; s_start = n_start; s_end = n_end;
    host_tx[0] = 8'hC3;
    spi_frame(8, -1, 1'b0, 8'h00);
    check("after_rst_rx",    {24'd0, rx_data_o},     32'hC3);
    check("after_rst_valid", 32'(n_rxv - s_rxv),     32'd1);
    check("after_rst_frame", 32'(n_start - s_start + n_end - s_end), 32'd2);

    // One-cycle glitch on the SPI clock inside a frame.
    s_rxv = n_rxv; s_end = n_end; s_abort = n_abort;
    spi_csn = 1'b0;
    cyc(8);
    spi_clk = 1'b1;
    cyc(1);
    spi_clk = 1'b0;
    cyc(10);
    spi_csn = 1'b1;
    cyc(10);
`ifdef CELLRV32_SPI_TGT_CLK_FILTER_EN
    exp_abort = 0;
`else
    exp_abort = 1;
`endif
    check("glitch_abort",    32'(n_abort - s_abort), 32'(exp_abort));
    check("glitch_end",      32'(n_end - s_end),     32'd1);
    check("glitch_no_valid", 32'(n_rxv - s_rxv),     32'd0);

    // Disable acts as reset and empties the holding register.
    tx_write(8'h77);
    check("en_tx_full", {31'd0, tx_ready_o}, 32'd0);
    cf_enable = 1'b0;
    cyc(2);
    check("en_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check("en_rx_data",  {24'd0, rx_data_o},  32'h00);
    cf_enable = 1'b1;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cellrv32_spi_target_phy.md
Name: cellrv32_spi_target_phy

Overview:
SPI target (slave) physical interface: the responder end of the SPI link driven by the XIP/SPI host PHYs. It runs on the system clock `clk_i` and oversamples the external SPI pins. MOSI bits are shifted in MSB-first and delivered as bytes. Transmit bytes come from a one-entry holding register and are shifted out on MISO. Used as a flash/peripheral responder and as the bench counterpart for host-side PHYs.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on `spi_clk_i`, `spi_csn_i` and `spi_dat_i`. Range 2..3.
- TX_IDLE_BYTE, 8'hFF: byte shifted out when the holding register is empty at a byte boundary.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cf_enable_i  in  1  module enable; low acts as synchronous reset.
- cf_cpha_i  in  1  clock phase.
- cf_cpol_i  in  1  clock idle polarity.
- spi_csn_i  in  1  chip select, active low (asynchronous pin).
- spi_clk_i  in  1  SPI clock (asynchronous pin).
- spi_dat_i  in  1  MOSI.
- spi_dat_o  out  1  MISO.
- spi_dat_oe_o  out  1  MISO output enable.
- tx_data_i  in  8  next transmit byte.
- tx_valid_i  in  1  transmit byte offered.
- tx_ready_o  out  1  holding register empty.
- tx_underrun_o  out  1  1-cycle pulse: TX_IDLE_BYTE substituted.
- rx_data_o  out  8  last complete received byte.
- rx_valid_o  out  1  1-cycle pulse: `rx_data_o` updated.
- frame_start_o  out  1  1-cycle pulse on synced CS assertion.
- frame_end_o  out  1  1-cycle pulse on synced CS deassertion.
- rx_abort_o  out  1  1-cycle pulse: frame ended with 1..7 bits pending.
- busy_o  out  1  frame in progress.

Behaviour:
- Reset (`rst_i`=1 or `cf_enable_i`=0) forces:
  - All pulse outputs, `busy_o`, `spi_dat_oe_o` and `spi_dat_o` to 0.
  - `rx_data_o` to 8'h00.
  - `tx_ready_o` to 1, holding register empty, state to S_ARM.
- Synchronization: each pin passes through SYNC_STAGES flops. A `spi_clk` edge is a difference between the last synced sample and its previous value.
  - Pin-to-event latency is SYNC_STAGES+1 cycles.
  - `clk_i` must be at least 8x the SPI clock rate; faster SPI clocks are unsupported and unchecked.
- Edge roles:
  - Leading edge: transition away from `cf_cpol_i`. Trailing edge: transition back to it.
  - Sample edge is leading if `cf_cpha_i`=0, trailing if 1. Shift edge is the other one.
- FSM:
  - S_ARM: wait for synced CS high, then go to S_IDLE. After reset this prevents joining a frame mid-way.
  - S_IDLE: on synced CS low:
    - pulse `frame_start_o` and go to S_ACTIVE;
    - bitcnt <= 0;
    - txs <= holding register (hold then empties), or TX_IDLE_BYTE plus `tx_underrun_o` if empty.
  - S_ACTIVE, sample edge:
    - rxs <= {rxs[6:0], mosi}; bitcnt <= bitcnt+1 (3-bit, wraps 7->0).
    - On wrap: `rx_data_o` <= completed byte, `rx_valid_o` pulses the same cycle, byte_done <= 1.
  - S_ACTIVE, shift edge:
    - If byte_done: byte_done <= 0 and txs reloads (holding register or TX_IDLE_BYTE with underrun pulse).
    - Otherwise txs <= txs<<1.
    - cpha=1 only: the shift edge also registers `spi_dat_o` <= txs[7] before shifting. The first leading edge therefore presents the byte MSB.
  - MISO value: cpha=0, `spi_dat_o` = txs[7], valid from the load. cpha=1, registered as above.
  - CS deassertion in S_ACTIVE:
    - pulse `frame_end_o`; pulse `rx_abort_o` if bitcnt≠0;
    - discard partial rxs and txs; holding register kept; go to S_IDLE.
- Output enable and busy: `spi_dat_oe_o` = `busy_o` = (state==S_ACTIVE).
- Holding register:
  - Write occurs when `tx_valid_i` & `tx_ready_o`.
  - A reload in the same cycle sees the pre-write state: empty -> underrun, and the write still fills the register.
  - `tx_valid_i` while `tx_ready_o`=0 is ignored.
- Simultaneous CS deassert and edge: the CS event wins and the edge is ignored.
- Changing `cf_cpol_i`/`cf_cpha_i` outside S_IDLE/S_ARM is undefined.

Optional Feature:
CELLRV32_SPI_TGT_CLK_FILTER_EN:
- Defined: the synced `spi_clk` level is accepted only after 2 consecutive equal samples. This rejects 1-cycle glitches and adds 1 cycle of edge latency.
- Undefined: the raw synced level is used directly.

Test Plan:
- Mode 0, tx preloaded 8'hA5, host sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; `rx_data_o`=8'h3C with one `rx_valid_o` pulse; `frame_start_o`/`frame_end_o` one pulse each; no underrun.
- Mode 3, 3-byte frame, host 8'h03,8'h12,8'h34; tx 8'h11 preloaded and 8'h22 written after the first `tx_ready_o` -> MISO 8'h11,8'h22,8'hFF; exactly one `tx_underrun_o` (third byte); `rx_valid_o` x3.
- Modes 1 and 2, host sends 8'h81 -> `rx_data_o`=8'h81; MISO transitions only on shift edges.
- CS released after 5 bits -> `rx_abort_o`=1, `frame_end_o`=1, no `rx_valid_o`; next frame with 8'h55 received correctly.
- `rst_i` pulsed mid-frame, CS held low -> state held in S_ARM, no RX pulses until CS high; next frame normal.
- Filter macro defined, 1-cycle glitch on `spi_clk_i` -> no bit sampled; undefined -> spurious sample counted.
